// File: rtl/scan_pkg.sv
// Shared types and byte constants for the PS/2 scan-code decoder and its event FIFO.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } state_e;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;

  // Bytes following E1 that belong to the Pause/Break make sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } scan_ev_t;

  // Keyboard status/ack responses that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == B_FA) || (b == B_AA) || (b == B_EE) || (b == B_FE);
  endfunction

endpackage

// File: rtl/scan_fifo.sv
// Event FIFO: power-of-two depth, head presented straight from the storage registers.
module scan_fifo
  import scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  scan_ev_t                 din_i,
  input  logic                     pop_i,
  output scan_ev_t                 dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  scan_ev_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefixes into key events, queues them,
// and throttles the keyboard through inhibit when the queue is nearly full.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  input  logic       rx_err,
  output logic       inhibit,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  output logic       seq_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_INH  = (AW + 1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, seq_err_q;
  logic          tmo_hit, push, err_set, pop, full, empty;
  scan_ev_t      push_ev, head;
  logic [AW:0]   count;

  assign tmo_hit = (state_q != ST_IDLE) && !rx_err && !byte_vld && (tmo_q == TMO_LAST);
  assign pop     = ev_valid && ev_ready;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_q | (push && full && !pop);
      seq_err_q <= seq_err_q | err_set;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    if (rx_err || tmo_hit) begin
      state_d = ST_IDLE;
      skip_d  = '0;
      tmo_d   = '0;
    end else if (byte_vld) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (byte_in == B_E0)      state_d = ST_EXT;
          else if (byte_in == B_F0) state_d = ST_BRK;
          else if (byte_in == B_E1) begin
            state_d = ST_PAUSE;
            skip_d  = PAUSE_SKIP;
          end
        end
        ST_EXT:              state_d = (byte_in == B_F0) ? ST_EXTBRK : ST_IDLE;
        ST_BRK, ST_EXTBRK:   state_d = ST_IDLE;
        ST_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default:             state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    err_set = 1'b0;
    if (rx_err || tmo_hit) begin
      err_set = 1'b1;
    end else if (byte_vld) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_in == B_00 || byte_in == B_FF) err_set = 1'b1;
          else if (byte_in != B_E0 && byte_in != B_F0 && byte_in != B_E1 && !is_status(byte_in)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, brk: 1'b0, code: byte_in};
          end
        end
        ST_EXT: if (byte_in != B_F0) begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, brk: 1'b0, code: byte_in};
        end
        ST_BRK: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b0, brk: 1'b1, code: byte_in};
        end
        ST_EXTBRK: begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, brk: 1'b1, code: byte_in};
        end
        ST_PAUSE: if (skip_q == 3'd1) begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, brk: 1'b0, code: B_E1};
        end
        default: push = 1'b0;
      endcase
    end
  end

  scan_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_ev),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign ev_valid = !empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_brk   = head.brk;
  assign inhibit  = (count >= CNT_INH);
  assign ovf      = ovf_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: prefix decoding, FIFO flow control, timeout and reset.
module tb_scan_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 2000;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_vld = 1'b0;
  logic       rx_err = 1'b0;
  logic       ev_ready = 1'b0;
  logic       inhibit, ev_ext, ev_brk, ev_valid, ovf, seq_err;
  logic [7:0] ev_code;

  int n_pass = 0;
  int n_chk  = 0;

  scan_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .byte_in  (byte_in),
    .byte_vld (byte_vld),
    .rx_err   (rx_err),
    .inhibit  (inhibit),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ovf      (ovf),
    .seq_err  (seq_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] hd();
    return {5'b0, ev_valid, ev_ext, ev_brk, ev_code};
  endfunction

  function automatic logic [15:0] evx(input logic v, input logic e, input logic b, input logic [7:0] c);
    return {5'b0, v, e, b, c};
  endfunction

  // All tasks start and end on a falling edge.
  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in  = b;
    byte_vld = 1'b1;
    @(negedge sysclk);
    byte_vld = 1'b0;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(negedge sysclk);
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge sysclk);
    chk("reset_outputs", {9'b0, inhibit, ev_valid, ev_ext, ev_brk, ovf, seq_err, |ev_code}, 16'h0);
    rst_n = 1'b1;
    tick();

    // Make and break of a plain key, consumer always ready
    ev_ready = 1'b1;
    send(8'h1C);
    chk("make_1C", hd(), evx(1, 0, 0, 8'h1C));
    send(8'hF0);
    chk("popped_after_make", {15'b0, ev_valid}, 16'h0);
    send(8'h1C);
    chk("break_1C", hd(), evx(1, 0, 1, 8'h1C));
    tick();
    chk("break_popped", {15'b0, ev_valid}, 16'h0);
    ev_ready = 1'b0;

    // Extended make/break with status bytes in between
    send(8'hE0); send(8'h75);
    chk("ext_make", hd(), evx(1, 1, 0, 8'h75));
    send(8'hFA); send(8'hAA);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_make_still_head", hd(), evx(1, 1, 0, 8'h75));
    pop();
    chk("ext_break", hd(), evx(1, 1, 1, 8'h75));
    pop();
    chk("status_no_event", {15'b0, ev_valid}, 16'h0);
    pop();
    chk("pop_empty_noop", {15'b0, ev_valid}, 16'h0);

    // Fill to overflow with the consumer stalled
    send(8'h11); send(8'h22);
    chk("inhibit_cnt2", {15'b0, inhibit}, 16'h0);
    send(8'h33);
    chk("inhibit_cnt3", {15'b0, inhibit}, 16'h1);
    send(8'h44);
    chk("ovf_before", {15'b0, ovf}, 16'h0);
    send(8'h55);
    chk("ovf_set", {15'b0, ovf}, 16'h1);
    chk("head_kept", hd(), evx(1, 0, 0, 8'h11));
    pop();
    chk("q_22", hd(), evx(1, 0, 0, 8'h22));
    chk("inhibit_cnt3_after_pop", {15'b0, inhibit}, 16'h1);
    pop();
    chk("q_33", hd(), evx(1, 0, 0, 8'h33));
    chk("inhibit_release", {15'b0, inhibit}, 16'h0);
    pop();
    chk("q_44", hd(), evx(1, 0, 0, 8'h44));
    pop();
    chk("q_empty", {15'b0, ev_valid}, 16'h0);
    chk("ovf_sticky", {15'b0, ovf}, 16'h1);

    // Push into a full FIFO while the head is taken in the same cycle
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    byte_in = 8'h35; byte_vld = 1'b1; ev_ready = 1'b1;
    tick();
    byte_vld = 1'b0; ev_ready = 1'b0;
    chk("full_pushpop_head", hd(), evx(1, 0, 0, 8'h32));
    chk("full_pushpop_inh", {15'b0, inhibit}, 16'h1);
    pop(); pop(); pop();
    chk("full_pushpop_tail", hd(), evx(1, 0, 0, 8'h35));
    pop();
    chk("full_pushpop_empty", {15'b0, ev_valid}, 16'h0);

    // Timeout: one cycle short is still in time, one past is not
    do_reset();
    chk("seq_err_cleared", {14'b0, ovf, seq_err}, 16'h0);
    send(8'hE0);
    repeat (TMO - 1) tick();
    send(8'h75);
    chk("tmo_in_time", hd(), evx(1, 1, 0, 8'h75));
    chk("tmo_in_time_err", {15'b0, seq_err}, 16'h0);
    pop();
    send(8'hE0);
    repeat (TMO + 1) tick();
    chk("tmo_seq_err", {15'b0, seq_err}, 16'h1);
    chk("tmo_no_event", {15'b0, ev_valid}, 16'h0);
    send(8'h1C);
    chk("tmo_then_1C", hd(), evx(1, 0, 0, 8'h1C));
    pop();

    // Pause/Break yields a single event
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_partial", {15'b0, ev_valid}, 16'h0);
    send(8'h77);
    chk("pause_event", hd(), evx(1, 1, 0, 8'hE1));
    pop();
    chk("pause_single", {15'b0, ev_valid}, 16'h0);
    chk("pause_no_err", {15'b0, seq_err}, 16'h0);

    // Overrun byte and rx_err beating a same-cycle byte
    send(8'h00);
    chk("overrun_err", {15'b0, seq_err}, 16'h1);
    chk("overrun_no_event", {15'b0, ev_valid}, 16'h0);
    do_reset();
    send(8'hE0);
    byte_in = 8'h75; byte_vld = 1'b1; rx_err = 1'b1;
    tick();
    byte_vld = 1'b0; rx_err = 1'b0;
    chk("rxerr_err", {15'b0, seq_err}, 16'h1);
    chk("rxerr_no_event", {15'b0, ev_valid}, 16'h0);
    send(8'h75);
    chk("rxerr_then_idle", hd(), evx(1, 0, 0, 8'h75));

    // Asynchronous reset mid-sequence with events queued
    do_reset();
    send(8'h11); send(8'h22); send(8'hF0);
    chk("pre_reset_head", hd(), evx(1, 0, 0, 8'h11));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {5'b0, inhibit, ev_valid, ev_ext, ev_brk, ev_code}, 16'h0);
    @(negedge sysclk);
    rst_n = 1'b1;
    send(8'h1C);
    chk("post_reset_1C", hd(), evx(1, 0, 0, 8'h1C));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
